systolic_mm_core: RTL and testbench
===================================

Name: systolic_mm_core

Overview:
- N x M output-stationary systolic array that computes C = A x B over an inner dimension K, using a controller and a grid of MAC processing elements.
- The controller sequences skewed operand injection and holds the results until the host acknowledges them.
- The core sits between the operand-streaming host logic and the result readout in the accelerator datapath.

Parameters:
- DATA_WIDTH, 32, width of operands, products and accumulators.
- N, 3, number of PE rows (rows of A and C).
- M, 3, number of PE columns (columns of B and C).
- K, 3, inner dimension (columns of A, rows of B).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  N*DATA_WIDTH  row operand streams; row i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- b_in  input  M*DATA_WIDTH  column operand streams; column j occupies slice [j*DATA_WIDTH +: DATA_WIDTH].
- finished  input  1  host acknowledge that results have been read.
- a_en  output  N  a_en[i] high means a_in row i is consumed this cycle.
- b_en  output  M  b_en[j] high means b_in column j is consumed this cycle.
- load  output  1  accumulate enable broadcast to all PEs.
- done  output  1  results valid on c_out.
- c_out  output  N*M*DATA_WIDTH  C[i][j] at slice index (i*M+j).

Behaviour:
- Reset (async): state IDLE, counter 0, all PE accumulators and pipe registers 0, load=0, done=0, a_en=b_en=0.
- States: IDLE, FEED, DONE.
- IDLE: lasts 1 cycle. Asserts internal clr, which synchronously zeroes all accumulators and pipes. Unconditional move to FEED.
- FEED:
  - load=1; counter t runs 0 .. T-1, with T = N+M+K-2 (7 at defaults).
  - a_en[i] = (i <= t <= i+K-1); b_en[j] = (j <= t <= j+K-1). Both are combinational from the state and counter.
  - Host presents A[i][t-i] on row i and B[t-j][j] on column j whenever the matching enable is high.
  - Gating: an operand entering the array is the input value when its enable is high, else 0.
  - At t = T-1, move to DONE.
- DONE: load=0, done=1, enables 0, c_out held. finished=1 moves to IDLE (new computation). finished is ignored in IDLE and FEED.
- PE(i,j):
  - a-input comes from the gated row i stream when j==0, else from PE(i,j-1).a_out.
  - b-input comes from the gated column j stream when i==0, else from PE(i-1,j).b_out.
  - Each clock: a_out<=a_in, b_out<=b_in (1-cycle forward latency).
  - If load: acc <= acc + a_in*b_in, truncated to DATA_WIDTH (mod 2^DATA_WIDTH, sign-agnostic). clr overrides load and zeroes acc, a_out and b_out.
- Timing: A[i][k] and B[k][j] meet at PE(i,j) in cycle t = i+j+k. The final product lands at PE(N-1,M-1) in t = T-1, so c_out is valid on the first DONE cycle.
- Operand-to-result latency: T cycles after FEED entry.
- Reset mid-FEED: abort, all state cleared, restart via IDLE after reset release.

Decomposition:
- Package systolic_pkg holds the default DATA_WIDTH/N/M/K constants and the state enum (IDLE, FEED, DONE).
- One sub-module, mac_pe: the single PE with clk, rst, clr, load, a_in, b_in, a_out, b_out, c_out.
- The controller FSM and the generate grid of N*M mac_pe instances live in systolic_mm_core.

Test Plan:
- Reset/sequence: release rst, then 1 IDLE cycle, then 7 FEED cycles with load=1, then done=1. Check a_en = 001,011,111,110,100,000,000 (bit0 first listed as LSB pattern per t) and b_en identical.
- A = B = [[1,2,3],[4,5,6],[7,8,9]] -> c_out rows {30,36,42},{66,81,96},{102,126,150}, held while finished=0.
- A = identity, B = [[9,8,7],[6,5,4],[3,2,1]] -> C = B. Then pulse finished, rerun with all-ones A and B -> every C = 3 (confirms clr between runs).
- Overflow: A[0][0] = 0xFFFFFFFF, B[0][0] = 2, other operands 0 -> C[0][0] = 0xFFFFFFFE, all others 0.
- finished=1 held during FEED -> ignored; done still rises at t = 7 with correct results.
- rst asserted at FEED t=3 -> load, done and enables drop to 0 immediately and c_out = 0; after release a full new run completes correctly.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and types for the output-stationary systolic matrix core.
//   DEF_DATA_WIDTH / DEF_N / DEF_M / DEF_K : default operand width and array shape
//   state_e                                : controller states (IDLE, FEED, DONE)
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_N          = 3;
    localparam int DEF_M          = 3;
    localparam int DEF_K          = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mac_pe.sv
// Single multiply-accumulate processing element of the systolic grid.
// Operands pass straight through with one cycle of latency; the accumulator
// stays in place (output-stationary) and is presented on c_out.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous clear of accumulator and operand pipes
//   load          : accumulate enable
//   a_in, b_in    : operands arriving from the left / from above
//   a_out, b_out  : registered operands forwarded right / down
//   c_out         : accumulated result (wraps mod 2^DATA_WIDTH)
module mac_pe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] c_out
);

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] prod;

    // Product and sum are kept at DATA_WIDTH: the result is the low bits,
    // identical for signed and unsigned interpretations.
    assign prod  = a_in * b_in;
    assign acc_d = acc_q + prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clr) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
            if (load) begin
                acc_q <= acc_d;
            end
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign c_out = acc_q;

endmodule

// File: rtl/systolic_mm_core.sv
// N x M output-stationary systolic array computing C = A x B over inner
// dimension K. A controller clears the grid for one cycle (IDLE), streams
// skewed operands for T = N+M+K-2 cycles (FEED), then holds the results with
// done=1 until the host acknowledges with finished (DONE).
//
// Handshake: a_en[i] / b_en[j] high in a cycle means the operand on that
// row/column stream is consumed at the next rising edge; when low, the
// stream value is ignored and a zero enters the array instead. done=1 means
// c_out is valid and stable; finished=1 while done=1 releases the results
// and starts a new run. finished is ignored in any other state.
//
//   clk, rst  : clock, asynchronous active-high reset
//   a_in      : row streams, row i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_in      : column streams, column j at [j*DATA_WIDTH +: DATA_WIDTH]
//   finished  : host acknowledge of the results
//   a_en, b_en: per-row / per-column consume strobes
//   load      : accumulate enable broadcast to the grid
//   done      : results valid on c_out
//   c_out     : C[i][j] at slice (i*M+j)
module systolic_mm_core
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N,
    parameter int M          = DEF_M,
    parameter int K          = DEF_K
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*DATA_WIDTH-1:0]     a_in,
    input  logic [M*DATA_WIDTH-1:0]     b_in,
    input  logic                        finished,
    output logic [N-1:0]                a_en,
    output logic [M-1:0]                b_en,
    output logic                        load,
    output logic                        done,
    output logic [N*M*DATA_WIDTH-1:0]   c_out
);

    localparam int T     = N + M + K - 2;
    localparam int CNT_W = (T > 1) ? $clog2(T) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             load_q;
    logic             done_q;
    logic             clr;
    logic [31:0]      t_ext;

    // Controller: load/done are registered alongside the state so they
    // change on the same edge as the state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FEED;
                    cnt_q   <= '0;
                    load_q  <= 1'b1;
                end
                FEED: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        load_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (finished) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    load_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load  = load_q;
    assign done  = done_q;
    assign clr   = (state_q == IDLE);
    assign t_ext = 32'(cnt_q);

    // Skew: row i / column j is live for the K cycles starting at t = i / j.
    always_comb begin
        a_en = '0;
        b_en = '0;
        if (state_q == FEED) begin
            for (int i = 0; i < N; i++) begin
                if (t_ext >= 32'(i) && t_ext <= 32'(i + K - 1)) a_en[i] = 1'b1;
            end
            for (int j = 0; j < M; j++) begin
                if (t_ext >= 32'(j) && t_ext <= 32'(j + K - 1)) b_en[j] = 1'b1;
            end
        end
    end

    logic [DATA_WIDTH-1:0] a_gated [N];
    logic [DATA_WIDTH-1:0] b_gated [M];
    logic [DATA_WIDTH-1:0] a_pipe  [N][M];
    logic [DATA_WIDTH-1:0] b_pipe  [N][M];
    logic                  edge_unused;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_gated[i] = a_en[i] ? a_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        for (int j = 0; j < M; j++) begin
            b_gated[j] = b_en[j] ? b_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Operands leaving the right column / bottom row have no consumer.
    always_comb begin
        edge_unused = 1'b0;
        for (int i = 0; i < N; i++) edge_unused = edge_unused ^ (^a_pipe[i][M-1]);
        for (int j = 0; j < M; j++) edge_unused = edge_unused ^ (^b_pipe[N-1][j]);
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < M; j++) begin : g_col
            logic [DATA_WIDTH-1:0] pe_a_in;
            logic [DATA_WIDTH-1:0] pe_b_in;

            if (j == 0) begin : g_a_edge
                assign pe_a_in = a_gated[i];
            end else begin : g_a_inner
                assign pe_a_in = a_pipe[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign pe_b_in = b_gated[j];
            end else begin : g_b_inner
                assign pe_b_in = b_pipe[i-1][j];
            end

            mac_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .load  (load_q),
                .a_in  (pe_a_in),
                .b_in  (pe_b_in),
                .a_out (a_pipe[i][j]),
                .b_out (b_pipe[i][j]),
                .c_out (c_out[(i*M+j)*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_systolic_mm_core.sv
module tb_systolic_mm_core;

    typedef logic [31:0] mat_t [0:2][0:2];

    logic        clk;
    logic        rst;
    logic [95:0] a_in;
    logic [95:0] b_in;
    logic        finished;
    logic [2:0]  a_en;
    logic [2:0]  b_en;
    logic        load;
    logic        done;
    logic [287:0] c_out;

    int total;
    int bad;

    logic [2:0] exp_en [0:6];

    systolic_mm_core dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .finished (finished),
        .a_en     (a_en),
        .b_en     (b_en),
        .load     (load),
        .done     (done),
        .c_out    (c_out)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every C element against the expected matrix.
    task automatic check_c(input string tag, input mat_t exp_c);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                logic [31:0] got;
                got = c_out[(i*3+j)*32 +: 32];
                total++;
                if (got !== exp_c[i][j]) begin
                    bad++;
                    $display("FAIL %s C[%0d][%0d] got=%h exp=%h", tag, i, j, got, exp_c[i][j]);
                end
            end
        end
    endtask

    // Must be called at a negedge with the DUT in IDLE. Drives one FEED
    // window; inputs outside the enable window carry junk that must be gated.
    // abort_at >= 0 returns right after driving that FEED cycle.
    task automatic feed(input string tag, input mat_t a, input mat_t b,
                        input logic hold_finished, input int abort_at);
        #1;
        total++;
        if (load !== 1'b0 || done !== 1'b0 || a_en !== 3'b000 || b_en !== 3'b000) begin
            bad++;
            $display("FAIL %s idle load=%b done=%b a_en=%b b_en=%b exp all 0", tag, load, done, a_en, b_en);
        end
        finished = hold_finished;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int k;
                k = t - i;
                a_in[i*32 +: 32] = (k >= 0 && k < 3) ? a[i][k] : (32'hA5A5_0000 | 32'(t));
                b_in[i*32 +: 32] = (k >= 0 && k < 3) ? b[k][i] : (32'h5A5A_0000 | 32'(t));
            end
            #1;
            total++;
            if (load !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s feed t=%0d load=%b done=%b exp load=1 done=0", tag, t, load, done);
            end
            total++;
            if (a_en !== exp_en[t] || b_en !== exp_en[t]) begin
                bad++;
                $display("FAIL %s enables t=%0d a_en=%b b_en=%b exp=%b", tag, t, a_en, b_en, exp_en[t]);
            end
            if (t == abort_at) return;
        end
        @(negedge clk);
        finished = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || load !== 1'b0 || a_en !== 3'b000 || b_en !== 3'b000) begin
            bad++;
            $display("FAIL %s done_phase done=%b load=%b a_en=%b b_en=%b exp done=1 rest 0", tag, done, load, a_en, b_en);
        end
    endtask

    // Acknowledge results from DONE; leaves the DUT in IDLE at a negedge.
    task automatic ack();
        @(negedge clk);
        finished = 1'b1;
        @(negedge clk);
        finished = 1'b0;
    endtask

    mat_t m_seq, m_sq_c, m_id, m_rev, m_ones, m_three, m_ovf_a, m_ovf_b, m_ovf_c, m_zero;

    task automatic test_reset();
        rst = 1'b1;
        finished = 1'b0;
        a_in = '1;
        b_in = '1;
        #2;
        total++;
        if (load !== 1'b0 || done !== 1'b0 || a_en !== 3'b000 || b_en !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs load=%b done=%b a_en=%b b_en=%b exp 0", load, done, a_en, b_en);
        end
        repeat (3) @(negedge clk);
        check_c("reset_c", m_zero);
        rst = 1'b0;
    endtask

    task automatic test_square();
        feed("square", m_seq, m_seq, 1'b0, -1);
        check_c("square", m_sq_c);
        repeat (4) @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL square_hold done=%b exp=1", done);
        end
        check_c("square_hold", m_sq_c);
        ack();
    endtask

    task automatic test_identity_then_ones();
        feed("identity", m_id, m_rev, 1'b0, -1);
        check_c("identity", m_rev);
        ack();
        feed("ones", m_ones, m_ones, 1'b0, -1);
        check_c("ones", m_three);
        ack();
    endtask

    task automatic test_overflow();
        feed("overflow", m_ovf_a, m_ovf_b, 1'b0, -1);
        check_c("overflow", m_ovf_c);
        ack();
    endtask

    task automatic test_finished_during_feed();
        feed("fin_in_feed", m_seq, m_seq, 1'b1, -1);
        check_c("fin_in_feed", m_sq_c);
        ack();
    endtask

    task automatic test_reset_mid_feed();
        feed("abort", m_seq, m_seq, 1'b0, 3);
        rst = 1'b1;
        #1;
        total++;
        if (load !== 1'b0 || done !== 1'b0 || a_en !== 3'b000 || b_en !== 3'b000) begin
            bad++;
            $display("FAIL abort_outputs load=%b done=%b a_en=%b b_en=%b exp 0", load, done, a_en, b_en);
        end
        check_c("abort_c", m_zero);
        @(negedge clk);
        rst = 1'b0;
        feed("after_abort", m_id, m_rev, 1'b0, -1);
        check_c("after_abort", m_rev);
        ack();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_en = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
        m_zero  = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        m_seq   = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        m_sq_c  = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
        m_id    = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
        m_rev   = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
        m_ones  = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
        m_three = '{'{3, 3, 3}, '{3, 3, 3}, '{3, 3, 3}};
        m_ovf_a = '{'{32'hFFFF_FFFF, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        m_ovf_b = '{'{2, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        m_ovf_c = '{'{32'hFFFF_FFFE, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};

        test_reset();
        test_square();
        test_identity_then_ones();
        test_overflow();
        test_finished_during_feed();
        test_reset_mid_feed();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
